// File: rtl/beam_thresh_sequencer_pkg.sv
// Shared types and helpers for the beam threshold load controller.
package beam_ctrl_pkg;

   localparam int THRESH_BITS = 18;

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      UPDATE
   } bts_state_t;

   // DSPs compare against a negative threshold, so magnitudes go out negated.
   function automatic logic signed [THRESH_BITS-1:0] thresh_to_dsp(input logic [THRESH_BITS-1:0] mag);
      logic [THRESH_BITS-1:0] neg;
      neg = ~mag + {{(THRESH_BITS-1){1'b0}}, 1'b1};
      return $signed(neg);
   endfunction

endpackage

// File: rtl/thresh_shadow_ram.sv
// Shadow threshold store: one synchronous write port, one asynchronous read port.
module thresh_shadow_ram
   import beam_ctrl_pkg::*;
#(
   parameter int                     NBEAMS         = 48,
   parameter logic [THRESH_BITS-1:0] DEFAULT_THRESH = 18'd4000,
   parameter int                     AW             = $clog2(NBEAMS)
) (
   input  logic                   clk_i,
   input  logic                   wr_en_i,
   input  logic [AW-1:0]          wr_addr_i,
   input  logic [THRESH_BITS-1:0] wr_dat_i,
   input  logic [AW-1:0]          rd_addr_i,
   output logic [THRESH_BITS-1:0] rd_dat_o
);

   // Entries are held XOR DEFAULT_THRESH so the all-zero power-up state of the
   // fabric reads back as DEFAULT_THRESH without any reset or init sequence.
   logic [THRESH_BITS-1:0] mem_q [NBEAMS];

   always_ff @(posedge clk_i) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= wr_dat_i ^ DEFAULT_THRESH;
      end
   end

   assign rd_dat_o = mem_q[rd_addr_i] ^ DEFAULT_THRESH;

endmodule

// File: rtl/beam_thresh_sequencer.sv
// Walks every beam's shadow threshold onto the shared bus, then fires one global update.
module beam_thresh_sequencer
   import beam_ctrl_pkg::*;
#(
   parameter int                     NBEAMS         = 48,
   parameter logic [THRESH_BITS-1:0] DEFAULT_THRESH = 18'd4000,
   parameter int                     AW             = $clog2(NBEAMS)
) (
   input  logic                          clk_i,
   input  logic                          rst_i,
   input  logic                          wr_i,
   input  logic [AW-1:0]                 wr_addr_i,
   input  logic [THRESH_BITS-1:0]        wr_dat_i,
   input  logic                          commit_i,
   output logic                          busy_o,
   output logic signed [THRESH_BITS-1:0] thresh_o,
   output logic [NBEAMS-1:0]             thresh_ce_o,
   output logic                          update_o
);

   localparam logic [AW:0]        DEPTH    = (AW+1)'(NBEAMS);
   localparam logic [AW-1:0]      LAST     = AW'(NBEAMS-1);
   localparam logic [NBEAMS-1:0]  CE_FIRST = NBEAMS'(1);

   bts_state_t                    state_q;
   logic [AW-1:0]                 cnt_q;
   logic                          pending_q;
   logic signed [THRESH_BITS-1:0] thresh_q;
   logic [NBEAMS-1:0]             ce_q;
   logic                          update_q;

   logic                          wr_ok;
   logic                          start;
   logic [AW-1:0]                 rd_addr_d;
   logic [THRESH_BITS-1:0]        rd_mag;

   assign wr_ok = wr_i && ({1'b0, wr_addr_i} < DEPTH);
   assign start = commit_i || pending_q;

   // Read one beam ahead so the registered bus carries beam cnt_q.
   assign rd_addr_d = (state_q == LOAD && cnt_q != LAST) ? cnt_q + 1'b1 : '0;

   thresh_shadow_ram #(
      .NBEAMS         (NBEAMS),
      .DEFAULT_THRESH (DEFAULT_THRESH),
      .AW             (AW)
   ) u_shadow (
      .clk_i     (clk_i),
      .wr_en_i   (wr_ok),
      .wr_addr_i (wr_addr_i),
      .wr_dat_i  (wr_dat_i),
      .rd_addr_i (rd_addr_d),
      .rd_dat_o  (rd_mag)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pending_q <= 1'b0;
         thresh_q  <= '0;
         ce_q      <= '0;
         update_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= LOAD;
                  cnt_q     <= '0;
                  // Beam 0 is read on this very edge; a write to it would be missed.
                  pending_q <= wr_ok && (wr_addr_i == '0);
                  thresh_q  <= thresh_to_dsp(rd_mag);
                  ce_q      <= CE_FIRST;
               end
            end
            LOAD: begin
               pending_q <= pending_q | commit_i | wr_ok;
               if (cnt_q == LAST) begin
                  state_q  <= UPDATE;
                  thresh_q <= '0;
                  ce_q     <= '0;
                  update_q <= 1'b1;
               end else begin
                  cnt_q    <= cnt_q + 1'b1;
                  thresh_q <= thresh_to_dsp(rd_mag);
                  ce_q     <= ce_q << 1;
               end
            end
            UPDATE: begin
               pending_q <= pending_q | commit_i | wr_ok;
               update_q  <= 1'b0;
               state_q   <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy_o      = (state_q != IDLE) | pending_q;
   assign thresh_o    = thresh_q;
   assign thresh_ce_o = ce_q;
   assign update_o    = update_q;

endmodule

// File: doc/beam_thresh_sequencer.md
# beam_thresh_sequencer

Threshold load controller for a bank of dual-beam trigger modules. It holds a shadow copy of every beam's threshold and accepts random-access writes from the register side. On commit, it walks all beams over a shared 18-bit threshold bus, asserting exactly one beam's threshold clock-enable per cycle. It then issues a single global `update` pulse so that all beam DSPs switch to the new thresholds on the same clock.

## Interface

Parameters:
- `NBEAMS`, 48: total beams; must be even; `NBEAMS/2` dual-beam modules.
- `DEFAULT_THRESH`, 18'd4000: power-up contents of every shadow entry (positive magnitude).
- `AW`, `$clog2(NBEAMS)`: beam address width.

Ports:
- `clk_i`  in  1  system clock; the only clock.
- `rst_i`  in  1  reset; synchronous, active-high.
- `wr_i`  in  1  shadow write strobe.
- `wr_addr_i`  in  AW  beam index for the write; indices ≥ NBEAMS are ignored.
- `wr_dat_i`  in  18  threshold magnitude (unsigned).
- `commit_i`  in  1  request a full load sweep; single-cycle pulse or level.
- `busy_o`  out  1  sweep in progress or pending.
- `thresh_o`  out  18  shared threshold bus, in two's complement.
- `thresh_ce_o`  out  NBEAMS  one-hot load enable. Bits `[2p+1:2p]` drive `thresh_ce_i` of dual module p (bit 0 is beam A, bit 1 is beam B).
- `update_o`  out  1  one-cycle pulse fanned out to every module's `update_i`.

## Operation

- **Shadow store**
  - NBEAMS × 18 storage holding magnitudes.
  - FPGA-initialised to `DEFAULT_THRESH`; not cleared by `rst_i`.
  - Writes take effect at the clock edge where `wr_i` is high, in any state.
- **Conversion.** `thresh_o = (~mag + 1) mod 2^18`. Magnitude 0 maps to 0. This value is computed in the block; software always writes positive magnitudes.
- **FSM states: IDLE, LOAD, UPDATE.**
  - **IDLE → LOAD** when `commit_i` or `pending` is set. Beam counter ← 0; `pending` ← 0.
  - **LOAD:** each cycle, present beam `cnt` on `thresh_o` with `thresh_ce_o = 1<<cnt`, then increment. After `cnt == NBEAMS-1`, go to UPDATE.
  - **UPDATE:** `update_o` = 1 for one cycle, then IDLE.
- **Pending flag**
  - Set by `commit_i` or by a valid `wr_i` while the FSM is in LOAD or UPDATE.
  - This guarantees any write landing mid-sweep is reloaded by a following sweep, so no write is ever stranded.
  - Multiple requests collapse into a single pending sweep.
- `busy_o` = (state ≠ IDLE) | pending.
- Partial sweeps never become active: DSPs swap thresholds only on `update_o`.

## Timing

- **Reset values:** `thresh_o` = 0, `thresh_ce_o` = 0, `update_o` = 0, `busy_o` = 0, state IDLE, `pending` = 0, counter 0.
- **Registered outputs.** `commit_i` sampled high in IDLE at edge k gives:
  - beam b loaded (ce high, data valid) in cycle k+1+b;
  - `update_o` high in cycle k+NBEAMS+1;
  - `busy_o` high from cycle k+1 through k+NBEAMS+1 (longer if pending).
- **Sweep length.** A sweep occupies NBEAMS+1 cycles. A pending sweep starts with beam 0 in the cycle after UPDATE plus one (the IDLE pass-through cycle).
- **Write/load collision.** A write and the read of the same beam on the same edge: the load uses the old value, and the pending flag guarantees a correct reload.
- **Reset mid-sweep**
  - Outputs return to their reset values on the next cycle.
  - No `update_o` is issued.
  - DSPs retain the previously active thresholds.
  - Pending is cleared.
- `commit_i` held high re-triggers continuously: back-to-back sweeps with one IDLE cycle between them.

## Structure

- **Package `beam_ctrl_pkg`:**
  - `THRESH_BITS = 18`;
  - state enum `bts_state_t {IDLE, LOAD, UPDATE}`;
  - function `thresh_to_dsp(mag)` returning the two's complement.
- **Sub-module `thresh_shadow_ram`:**
  - NBEAMS × 18 distributed RAM;
  - one synchronous write port and one asynchronous read port;
  - INIT from `DEFAULT_THRESH`.
- The top level holds the FSM, counter, pending flag and output registers.

## Test plan

- **Power-up sweep.** Release reset, pulse `commit_i` at cycle 0.
  - `thresh_ce_o` walks one-hot bits 0..47 in cycles 1..48, with `thresh_o = 0x3F060` (−4000).
  - `update_o` is high in cycle 49 only.
  - `busy_o` falls in cycle 50.
- **Conversion.** Write beam 5 = 1000, beam 6 = 0, beam 47 = 0x1FFFF, then commit.
  - Beam 5 shows 0x3FC18, beam 6 shows 0x00000, beam 47 shows 0x20001 in their respective load cycles.
- **Write mid-sweep.** Write beam 3 = 500 during the cycle loading beam 20.
  - `busy_o` stays high; a second sweep follows with one IDLE cycle between.
  - In the second sweep, beam 3 = 0x3FE0C; exactly two `update_o` pulses in total.
- **Commit coalescing.** Pulse `commit_i` three times during one sweep.
  - Exactly one extra sweep and two `update_o` pulses in total.
- **Reset at beam 30.** Assert `rst_i` for 1 cycle.
  - All outputs are 0 next cycle; no `update_o` is issued.
  - A new commit restarts at beam 0 with the shadow contents preserved.
- **Out-of-range write.** Write to address 50 (NBEAMS = 48).
  - Shadow is unchanged; a subsequent sweep shows all defaults.
  - `pending` is not set by that write.
